pipe_hazard_ctrl: RTL and testbench

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_hazard_ctrl_pkg.sv | 14 +
 rtl/pipe_hazard_ctrl_hazard_detect.sv | 21 ++
 rtl/pipe_hazard_ctrl.sv | 119 +++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// rtl/pipe_hazard_ctrl_pkg.sv - shared pipeline-control encodings and FSM state type
package pipe_hazard_ctrl_pkg;

  // Per-register control: bit0 = flush, bit1 = stall/hold
  localparam logic [1:0] SF_RUN   = 2'b00;
  localparam logic [1:0] SF_FLUSH = 2'b01;
  localparam logic [1:0] SF_STALL = 2'b10;

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_MEM_WAIT = 1'b1
  } state_t;

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// rtl/pipe_hazard_ctrl_hazard_detect.sv - combinational load-use dependency compare
module hazard_detect (
  input  logic [4:0] id_rs1_addr,
  input  logic [4:0] id_rs2_addr,
  input  logic       id_rs1_used,
  input  logic       id_rs2_used,
  input  logic       ex_mem_r,
  input  logic [4:0] ex_rd_addr,
  output logic       load_use
);

  logic w_rs1_hit;
  logic w_rs2_hit;

  assign w_rs1_hit = id_rs1_used && (id_rs1_addr == ex_rd_addr);
  assign w_rs2_hit = id_rs2_used && (id_rs2_addr == ex_rd_addr);

  // x0 is hardwired to zero, so a load targeting it never produces a dependency
  assign load_use = ex_mem_r && (ex_rd_addr != 5'd0) && (w_rs1_hit || w_rs2_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - pipeline stall/flush controller with memory-wait watchdog
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYC = 1024,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs1_addr,
  input  logic [4:0]       id_rs2_addr,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic             ex_mem_r,
  input  logic [4:0]       ex_rd_addr,
  input  logic             ex_branch_taken,
  input  logic             im_wait,
  input  logic             dm_wait,
  output logic [1:0]       sf_if_id,
  output logic [1:0]       sf_id_ex,
  output logic [1:0]       sf_ex_mem,
  output logic [1:0]       sf_mem_wb,
  output logic             pc_stall,
  output logic [CNT_W-1:0] stall_cnt,
  output logic             wd_err
);

  localparam int              WC_W    = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [WC_W-1:0] WC_LAST = WC_W'(TIMEOUT_CYC - 1);

  state_t           r_state;
  logic             r_pend_flush;
  logic [WC_W-1:0]  r_wcnt;
  logic [CNT_W-1:0] r_stall_cnt;
  logic             r_wd_err;

  logic w_wait;
  logic w_load_use;
  logic w_br_eff;

  hazard_detect u_hazard_detect (
    .id_rs1_addr (id_rs1_addr),
    .id_rs2_addr (id_rs2_addr),
    .id_rs1_used (id_rs1_used),
    .id_rs2_used (id_rs2_used),
    .ex_mem_r    (ex_mem_r),
    .ex_rd_addr  (ex_rd_addr),
    .load_use    (w_load_use)
  );

  assign w_wait = im_wait | dm_wait;
  // pend_flush is only ever set while in MEM_WAIT and clears on exit
  assign w_br_eff = ex_branch_taken | r_pend_flush;

  always_comb begin
    sf_if_id  = SF_RUN;
    sf_id_ex  = SF_RUN;
    sf_ex_mem = SF_RUN;
    sf_mem_wb = SF_RUN;
    pc_stall  = 1'b0;
    if (w_wait) begin
      sf_if_id  = SF_STALL;
      sf_id_ex  = SF_STALL;
      sf_ex_mem = SF_STALL;
      sf_mem_wb = SF_STALL;
      pc_stall  = 1'b1;
    end else if (w_br_eff) begin
      sf_if_id = SF_FLUSH;
      sf_id_ex = SF_FLUSH;
    end else if (w_load_use) begin
      sf_if_id = SF_STALL;
      sf_id_ex = SF_FLUSH;
      pc_stall = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_RUN;
      r_pend_flush <= 1'b0;
      r_wcnt       <= '0;
      r_stall_cnt  <= '0;
      r_wd_err     <= 1'b0;
    end else begin
      if (pc_stall && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
      case (r_state)
        ST_RUN: begin
          if (w_wait) begin
            r_state      <= ST_MEM_WAIT;
            r_pend_flush <= ex_branch_taken;
            r_wcnt       <= '0;
          end
        end
        ST_MEM_WAIT: begin
          if (w_wait) begin
            r_pend_flush <= r_pend_flush | ex_branch_taken;
            // Counter parks at the limit; the FSM keeps waiting after the trip
            if (r_wcnt == WC_LAST) begin
              r_wd_err <= 1'b1;
            end else begin
              r_wcnt <= r_wcnt + 1'b1;
            end
          end else begin
            r_state      <= ST_RUN;
            r_pend_flush <= 1'b0;
            r_wcnt       <= '0;
          end
        end
        default: r_state <= ST_RUN;
      endcase
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign wd_err    = r_wd_err;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - directed scoreboard bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

  localparam logic [1:0] R = 2'b00;
  localparam logic [1:0] F = 2'b01;
  localparam logic [1:0] S = 2'b10;

  typedef struct packed {
    logic [1:0] if_id;
    logic [1:0] id_ex;
    logic [1:0] ex_mem;
    logic [1:0] mem_wb;
    logic       pc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  id_rs1_addr, id_rs2_addr, ex_rd_addr;
  logic        id_rs1_used, id_rs2_used, ex_mem_r, ex_branch_taken, im_wait, dm_wait;
  logic [1:0]  sf_if_id, sf_id_ex, sf_ex_mem, sf_mem_wb;
  logic        pc_stall, wd_err;
  logic [31:0] stall_cnt;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   exp_cnt = 0;

  pipe_hazard_ctrl #(.TIMEOUT_CYC(8), .CNT_W(32)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .id_rs1_addr     (id_rs1_addr),
    .id_rs2_addr     (id_rs2_addr),
    .id_rs1_used     (id_rs1_used),
    .id_rs2_used     (id_rs2_used),
    .ex_mem_r        (ex_mem_r),
    .ex_rd_addr      (ex_rd_addr),
    .ex_branch_taken (ex_branch_taken),
    .im_wait         (im_wait),
    .dm_wait         (dm_wait),
    .sf_if_id        (sf_if_id),
    .sf_id_ex        (sf_id_ex),
    .sf_ex_mem       (sf_ex_mem),
    .sf_mem_wb       (sf_mem_wb),
    .pc_stall        (pc_stall),
    .stall_cnt       (stall_cnt),
    .wd_err          (wd_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "time limit");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic mr, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic u1, input logic [4:0] rs2, input logic u2,
                        input logic br, input logic imw, input logic dmw);
    ex_mem_r        = mr;
    ex_rd_addr      = rd;
    id_rs1_addr     = rs1;
    id_rs1_used     = u1;
    id_rs2_addr     = rs2;
    id_rs2_used     = u2;
    ex_branch_taken = br;
    im_wait         = imw;
    dm_wait         = dmw;
  endtask

  // Inputs are already applied; push expectation, compare at negedge, advance one cycle
  task automatic cyc(input string tag, input exp_t e);
    exp_t got;
    q.push_back(e);
    @(negedge clk);
    got = q.pop_front();
    chk({tag, ".sf_if_id"},  32'(sf_if_id),  32'(got.if_id));
    chk({tag, ".sf_id_ex"},  32'(sf_id_ex),  32'(got.id_ex));
    chk({tag, ".sf_ex_mem"}, 32'(sf_ex_mem), 32'(got.ex_mem));
    chk({tag, ".sf_mem_wb"}, 32'(sf_mem_wb), 32'(got.mem_wb));
    chk({tag, ".pc_stall"},  32'(pc_stall),  32'(got.pc));
    chk({tag, ".stall_cnt"}, stall_cnt,      32'(exp_cnt));
    if (got.pc) exp_cnt++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst.sf_if_id", 32'(sf_if_id), 0);
    chk("rst.pc_stall", 32'(pc_stall), 0);
    chk("rst.stall_cnt", stall_cnt, 0);
    chk("rst.wd_err", 32'(wd_err), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    cyc("idle", '{R, R, R, R, 1'b0});

    // load-use on rs1, single bubble
    set_in(1, 5, 5, 1, 0, 0, 0, 0, 0);
    cyc("lu_rs1", '{S, F, R, R, 1'b1});
    set_in(0, 5, 5, 1, 0, 0, 0, 0, 0);
    cyc("lu_after", '{R, R, R, R, 1'b0});

    set_in(1, 0, 0, 1, 0, 0, 0, 0, 0);
    cyc("lu_x0", '{R, R, R, R, 1'b0});

    set_in(1, 7, 3, 1, 7, 1, 0, 0, 0);
    cyc("lu_rs2", '{S, F, R, R, 1'b1});
    set_in(1, 7, 3, 1, 7, 0, 0, 0, 0);
    cyc("lu_rs2_unused", '{R, R, R, R, 1'b0});

    // branch beats load-use
    set_in(1, 5, 5, 1, 0, 0, 1, 0, 0);
    cyc("br_lu", '{F, F, R, R, 1'b0});

    // dm_wait for 3 cycles
    for (int i = 0; i < 3; i++) begin
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 1);
      cyc("dm_wait", '{S, S, S, S, 1'b1});
    end
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc("dm_release", '{R, R, R, R, 1'b0});

    // im_wait 4 cycles, branch in cycle 2 -> flush on release
    for (int i = 0; i < 4; i++) begin
      set_in(0, 0, 0, 0, 0, 0, (i == 1), 1, 0);
      cyc("im_wait", '{S, S, S, S, 1'b1});
    end
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc("im_release", '{F, F, R, R, 1'b0});
    cyc("im_run", '{R, R, R, R, 1'b0});

    // wait beats branch and load-use on entry; the branch is remembered
    set_in(1, 5, 5, 1, 0, 0, 1, 0, 1);
    cyc("wait_prio", '{S, S, S, S, 1'b1});
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc("entry_br_release", '{F, F, R, R, 1'b0});
    cyc("entry_br_run", '{R, R, R, R, 1'b0});

    // watchdog with TIMEOUT_CYC=8
    for (int i = 0; i < 10; i++) begin
      set_in(0, 0, 0, 0, 0, 0, 0, 1, 0);
      if (i < 7) chk("wd_early", 32'(wd_err), 0);
      else if (i == 9) chk("wd_tripped", 32'(wd_err), 1);
      cyc("wd_wait", '{S, S, S, S, 1'b1});
    end
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc("wd_release", '{R, R, R, R, 1'b0});
    chk("wd_sticky", 32'(wd_err), 1);

    // reset in the middle of MEM_WAIT with a pending flush
    set_in(0, 0, 0, 0, 0, 0, 0, 1, 0);
    cyc("rst_wait1", '{S, S, S, S, 1'b1});
    set_in(0, 0, 0, 0, 0, 0, 1, 1, 0);
    cyc("rst_wait2", '{S, S, S, S, 1'b1});
    rst_n = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("mrst.sf_if_id", 32'(sf_if_id), 0);
    chk("mrst.sf_id_ex", 32'(sf_id_ex), 0);
    chk("mrst.pc_stall", 32'(pc_stall), 0);
    chk("mrst.stall_cnt", stall_cnt, 0);
    chk("mrst.wd_err", 32'(wd_err), 0);
    exp_cnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cyc("post_rst1", '{R, R, R, R, 1'b0});
    cyc("post_rst2", '{R, R, R, R, 1'b0});
    chk("queue_empty", 32'(q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
